// File: rtl/lcv_alu_rr_arbiter.sv
// Round-robin front end that shares one registered 1-cycle ALU among NUM_REQ clients.
// Each client gets its own response slot with a valid/ready handshake.
module lcv_alu_rr_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*8-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [NUM_REQ*WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0]         alu_inp_a,
    output logic [WIDTH-1:0]         alu_inp_b_0,
    output logic [WIDTH-1:0]         alu_inp_b_1,
    output logic                     alu_inp_b_sel,
    output logic [7:0]               alu_inp_op,
    input  logic [WIDTH-1:0]         alu_outp_data
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic             infl_v_q;
    logic [IDX_W-1:0] infl_idx_q;
    logic             resp_valid_q [NUM_REQ];
    logic [WIDTH-1:0] resp_data_q  [NUM_REQ];

    logic [NUM_REQ-1:0] elig;
    logic [7:0]         op_arr [NUM_REQ];
    logic [WIDTH-1:0]   a_arr  [NUM_REQ];
    logic [WIDTH-1:0]   b_arr  [NUM_REQ];
    logic               grant_v;
    logic               grant_ok;
    logic [IDX_W-1:0]   grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign op_arr[gi] = req_op[8*gi +: 8];
            assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];

            // A slot being drained this cycle may be re-granted: its new result lands two edges later.
            assign elig[gi] = req_valid[gi]
                            & ~(infl_v_q & (infl_idx_q == IDX_W'(gi)))
                            & (~resp_valid_q[gi] | resp_ready[gi]);

            assign req_ready[gi] = grant_ok & (grant_idx == IDX_W'(gi));
            assign resp_valid[gi] = resp_valid_q[gi];
            assign resp_data[WIDTH*gi +: WIDTH] = resp_data_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    resp_valid_q[gi] <= 1'b0;
                    resp_data_q[gi]  <= '0;
                end else if (infl_v_q && (infl_idx_q == IDX_W'(gi))) begin
                    resp_valid_q[gi] <= 1'b1;
                    resp_data_q[gi]  <= alu_outp_data;
                end else if (resp_valid_q[gi] && resp_ready[gi]) begin
                    resp_valid_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        grant_v   = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!grant_v && elig[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_ok = grant_v & rst_n;
    assign rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);

    // Idle cycles drive ZERO so the shared ALU sees a harmless op.
    assign alu_inp_op    = grant_ok ? op_arr[grant_idx] : 8'h80;
    assign alu_inp_a     = grant_ok ? a_arr[grant_idx]  : '0;
    assign alu_inp_b_0   = grant_ok ? b_arr[grant_idx]  : '0;
    assign alu_inp_b_1   = '0;
    assign alu_inp_b_sel = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            infl_v_q   <= 1'b0;
            infl_idx_q <= '0;
        end else begin
            infl_v_q <= grant_v;
            if (grant_v) begin
                infl_idx_q <= grant_idx;
                rr_ptr_q   <= rr_ptr_d;
            end
        end
    end
endmodule

// File: tb/tb_lcv_alu_rr_arbiter.sv
// Bench for lcv_alu_rr_arbiter: directed scenarios plus random traffic against a
// queue-based model of grants and result delivery; the shared ALU is modelled here.
module tb_lcv_alu_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_op = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '0;
    logic [N*W-1:0] resp_data;
    logic [W-1:0]   alu_inp_a, alu_inp_b_0, alu_inp_b_1;
    logic           alu_inp_b_sel;
    logic [7:0]     alu_inp_op;
    logic [W-1:0]   alu_q;

    always #5 clk = ~clk;

    lcv_alu_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_inp_a(alu_inp_a), .alu_inp_b_0(alu_inp_b_0), .alu_inp_b_1(alu_inp_b_1),
        .alu_inp_b_sel(alu_inp_b_sel), .alu_inp_op(alu_inp_op), .alu_outp_data(alu_q)
    );

    function automatic logic [W-1:0] alu_fn(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            8'h01:   return a + b;
            8'h02:   return a - b;
            8'h04:   return (a < b) ? W'(1) : W'(0);
            8'h08:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            8'h10:   return a & b;
            8'h20:   return a | b;
            8'h40:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Shared ALU: registered, not reset.
    always_ff @(posedge clk) alu_q <= alu_fn(alu_inp_op, alu_inp_a, alu_inp_b_0);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int           idx;
        logic [W-1:0] val;
        int           due;
    } pend_t;

    pend_t        pq[$];
    logic         m_rv [N];
    logic [W-1:0] m_rd [N];
    int           m_rr;
    int           cyc;

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < N; i++) begin
            m_rv[i] = 1'b0;
            m_rd[i] = '0;
        end
        m_rr = 0;
        cyc  = 0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int           g;
        bit           busy;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [N*W-1:0] exp_data;
        pend_t        e;
        @(negedge clk);
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            busy = 1'b0;
            foreach (pq[j]) if (pq[j].idx == i) busy = 1'b1;
            if (g < 0 && req_valid[i] && !busy && (!m_rv[i] || resp_ready[i])) g = i;
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        for (int i = 0; i < N; i++) begin
            exp_rv[i] = m_rv[i];
            exp_data[W*i +: W] = m_rd[i];
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("resp_valid", resp_valid, exp_rv);
        chk("resp_data", resp_data, exp_data);
        chk("alu_op", alu_inp_op, (g >= 0) ? req_op[8*g +: 8] : 8'h80);
        if (g >= 0) chk("alu_a", alu_inp_a, req_a[W*g +: W]);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (m_rv[i] && resp_ready[i]) m_rv[i] = 1'b0;
        for (int j = pq.size() - 1; j >= 0; j--) begin
            if (pq[j].due == cyc) begin
                m_rv[pq[j].idx] = 1'b1;
                m_rd[pq[j].idx] = pq[j].val;
                pq.delete(j);
            end
        end
        if (g >= 0) begin
            e.idx = g;
            e.val = alu_fn(req_op[8*g +: 8], req_a[W*g +: W], req_b[W*g +: W]);
            e.due = cyc + 1;
            pq.push_back(e);
            m_rr = (g + 1) % N;
            $display("cyc=%0d grant req=%0d op=%02h a=%08h b=%08h", cyc, g, req_op[8*g +: 8],
                     req_a[W*g +: W], req_b[W*g +: W]);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_valid", resp_valid, '0);
        chk("rst_data", resp_data, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic set_req(input int i, input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[8*i +: 8] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic single(input int i, input logic [7:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_v, input string tag);
        req_valid  = '0;
        resp_ready = '1;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        #1;
        chk({tag, "_rdy"}, req_ready, N'(1) << i);
        step();
        req_valid = '0;
        chk({tag, "_lat"}, resp_valid[i], 0);
        step();
        chk({tag, "_data"}, resp_data[W*i +: W], exp_v);
        chk({tag, "_vld"}, resp_valid[i], 1);
        step();
        chk({tag, "_clr"}, resp_valid[i], 0);
        chk({tag, "_keep"}, resp_data[W*i +: W], exp_v);
    endtask

    // Hold slot i full under backpressure, then free it and re-grant in the same cycle.
    task automatic bp_free(input int i, input logic [7:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input logic [W-1:0] exp1, input logic [7:0] op2, input logic [W-1:0] a2,
                           input logic [W-1:0] b2, input logic [W-1:0] exp2, input int hold);
        req_valid = '0;
        resp_ready = '1;
        resp_ready[i] = 1'b0;
        set_req(i, op1, a1, b1);
        req_valid[i] = 1'b1;
        step();
        step();
        chk("bp_data", resp_data[W*i +: W], exp1);
        chk("bp_vld", resp_valid[i], 1);
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("bp_hold", req_ready[i], 0);
            step();
        end
        chk("bp_kept", resp_data[W*i +: W], exp1);
        resp_ready[i] = 1'b1;
        set_req(i, op2, a2, b2);
        #1;
        chk("free_grant", req_ready[i], 1);
        step();
        chk("free_clr", resp_valid[i], 0);
        step();
        chk("free_data", resp_data[W*i +: W], exp2);
        chk("free_vld", resp_valid[i], 1);
        req_valid = '0;
        step();
    endtask

    initial begin
        model_reset();
        do_reset();

        single(0, 8'h01, 32'd5, 32'd7, 32'd12, "add");
        single(0, 8'h04, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        single(1, 8'h08, 32'hFFFF_FFFF, 32'd1, 32'd1, "slts");
        single(2, 8'h10, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, "and");
        single(3, 8'h20, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAFAF_AFAF, "or");
        single(0, 8'h40, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, "xor");

        bp_free(2, 8'h02, 32'd3, 32'd5, 32'hFFFF_FFFE, 8'h01, 32'd10, 32'd20, 32'd30, 3);
        bp_free(1, 8'h10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 8'h02, 32'd100, 32'd1, 32'd99, 1);

        // Round-robin with every requester busy from a fresh reset.
        do_reset();
        resp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, 8'h01, W'(i), W'(100));
        req_valid = '1;
        for (int k = 0; k < 2 * N; k++) begin
            #1;
            chk("rr_order", req_ready, N'(1) << (k % N));
            step();
        end

        // Reset in the cycle after a grant: the in-flight result must vanish.
        req_valid = '0;
        set_req(3, 8'h01, 32'd40, 32'd2);
        req_valid[3] = 1'b1;
        step();
        do_reset();
        req_valid = '1;
        #1;
        chk("post_rst_grant", req_ready, 1);
        repeat (3) step();
        chk("no_stale", resp_valid[3], 0);

        for (int t = 0; t < 400; t++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                int r;
                resp_ready[i] = ($urandom_range(0, 9) < 6);
                r = $urandom_range(0, 15);
                set_req(i, (r < 14) ? (8'h01 << (r % 8)) : 8'($urandom),
                        (r[0]) ? W'($urandom) : W'($urandom_range(0, 15)),
                        (r[1]) ? W'($urandom) : W'($urandom_range(0, 15)));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
